// File: rtl/regfile_mp_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the multi-port register file slice.
//   Default geometry is 32 x 32-bit with 2 read ports and 1 write port.
//   Every file of the slice imports this package for its parameter defaults.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NREAD  = 2;
    localparam int RF_NWRITE = 1;
    localparam int RF_AW     = $clog2(RF_DEPTH);

    typedef logic [RF_WIDTH-1:0] rf_word_t;
    typedef logic [RF_AW-1:0]    rf_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the read, write, issue and scoreboard signals of regfile_mp.
//   master : decode/writeback side (drives addresses, write data, issue)
//   slave  : the register file itself
//
//   rd_addr  [NREAD*AW]     packed read addresses, port p at [p*AW +: AW]
//   rd_data  [NREAD*WIDTH]  packed registered read data
//   rd_busy  [NREAD]        registered busy flag of each addressed register
//   wr_en    [NWRITE]       per-port write enable
//   wr_addr  [NWRITE*AW]    packed write addresses
//   wr_data  [NWRITE*WIDTH] packed write data
//   iss_en   [1]            mark iss_addr busy (producer issued)
//   iss_addr [AW]           register being allocated
//   busy_vec [DEPTH]        current scoreboard state
// ----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NREAD  = RF_NREAD,
    parameter int NWRITE = RF_NWRITE
) ();

    localparam int AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]     rd_addr;
    logic [NREAD*WIDTH-1:0]  rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic [NWRITE-1:0]       wr_en;
    logic [NWRITE*AW-1:0]    wr_addr;
    logic [NWRITE*WIDTH-1:0] wr_data;
    logic                    iss_en;
    logic [AW-1:0]           iss_addr;
    logic [DEPTH-1:0]        busy_vec;

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output wr_en,
        output wr_addr,
        output wr_data,
        output iss_en,
        output iss_addr,
        input  busy_vec
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  iss_en,
        input  iss_addr,
        output busy_vec
    );

endinterface : regfile_mp_if

// File: rtl/regfile_mp_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   One busy bit per register, tracking writes that are still in flight.
//   A bit is set when a producer issues to the register and cleared when any
//   write port writes it. When both happen in the same cycle the set wins,
//   because the newly issued producer supersedes the one now writing back.
//
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset, clears every busy bit
//   wr_en_i      per-port write enable
//   wr_addr_i    packed write addresses, port w at [w*AW +: AW]
//   iss_en_i     issue strobe
//   iss_addr_i   register being allocated
//   busy_o       current busy vector (state)
//   busy_next_o  busy vector after this cycle's clear/set
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NWRITE   = RF_NWRITE,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NWRITE-1:0]    wr_en_i,
    input  logic [NWRITE*AW-1:0] wr_addr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [DEPTH-1:0]     busy_o,
    output logic [DEPTH-1:0]     busy_next_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears first, then the issue set, so a same-cycle set overrides a clear.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en_i[w]) begin
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        // The hardwired zero register never has a pending producer.
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign busy_next_o = busy_d;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file between decode and writeback.
//   Reads are registered (one cycle latency); each read port also returns the
//   registered busy flag of the register it addressed. Writes land at the
//   clock edge; with two write ports hitting one address the higher port wins.
//   With ZERO_REG=1, register 0 always reads 0, drops writes and is never busy.
//
//   Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//   and the post-update busy bit onto the read ports. Without it a same-cycle
//   read sees the old value and the pre-update busy bit. The storage array
//   behaves identically in both builds.
//
//   clock   rising-edge clock
//   reset   asynchronous active-low reset; clears array, read outputs, busy
//   bus     regfile_mp_if.slave carrying read/write/issue ports and busy_vec
// ----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NREAD    = RF_NREAD,
    parameter int NWRITE   = RF_NWRITE,
    parameter int ZERO_REG = 1
) (
    input  logic         clock,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    // Storage kept as a packed 2-D vector so it resets and updates as a whole.
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;

    logic [NREAD*WIDTH-1:0] rd_data_q;
    logic [NREAD*WIDTH-1:0] rd_data_d;
    logic [NREAD-1:0]       rd_busy_q;
    logic [NREAD-1:0]       rd_busy_d;

    logic [DEPTH-1:0] busy_cur;
    logic [DEPTH-1:0] busy_nxt;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i       (clock),
        .rst_ni      (reset),
        .wr_en_i     (bus.wr_en),
        .wr_addr_i   (bus.wr_addr),
        .iss_en_i    (bus.iss_en),
        .iss_addr_i  (bus.iss_addr),
        .busy_o      (busy_cur),
        .busy_next_o (busy_nxt)
    );

    // Ports are applied in ascending order so the highest-index port that
    // targets an address is the one that sticks.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NWRITE; w++) begin
            if (bus.wr_en[w]) begin
                mem_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*WIDTH +: WIDTH];
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port selection. The bypass build reads the post-write view, which
    // already encodes port priority and the forced-zero register.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int p = 0; p < NREAD; p++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_d[p*WIDTH +: WIDTH] = mem_d[bus.rd_addr[p*AW +: AW]];
            rd_busy_d[p]                = busy_nxt[bus.rd_addr[p*AW +: AW]];
`else
            rd_data_d[p*WIDTH +: WIDTH] = mem_q[bus.rd_addr[p*AW +: AW]];
            rd_busy_d[p]                = busy_cur[bus.rd_addr[p*AW +: AW]];
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = busy_cur;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Instance A: 2 read / 2 write ports,
//   ZERO_REG=1. Instance B: 1 read / 1 write port, ZERO_REG=0. Expected
//   outputs are queued as stimulus is driven and compared one edge later.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) bus_a ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(1), .NWRITE(1)) bus_b ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) u_dut_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(1), .NWRITE(1), .ZERO_REG(0)) u_dut_b (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 0/1: A rd_data port0/1, 2/3: A rd_busy port0/1, 4: A busy_vec,
    // 5: B rd_data, 6: B rd_busy, 7: B busy_vec
    function automatic logic [31:0] fetch(input int sel);
        logic [31:0] v;
        case (sel)
            0:       v = bus_a.rd_data[31:0];
            1:       v = bus_a.rd_data[63:32];
            2:       v = {31'b0, bus_a.rd_busy[0]};
            3:       v = {31'b0, bus_a.rd_busy[1]};
            4:       v = bus_a.busy_vec;
            5:       v = bus_b.rd_data;
            6:       v = {31'b0, bus_b.rd_busy};
            default: v = bus_b.busy_vec;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare everything queued for that edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, fetch(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        bus_a.wr_en    = '0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        bus_a.iss_en   = 1'b0;
        bus_a.iss_addr = '0;
        bus_a.rd_addr  = '0;
        bus_b.wr_en    = '0;
        bus_b.wr_addr  = '0;
        bus_b.wr_data  = '0;
        bus_b.iss_en   = 1'b0;
        bus_b.iss_addr = '0;
        bus_b.rd_addr  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("reset_rd0", fetch(0), 32'h0);
        chk("reset_rd1", fetch(1), 32'h0);
        chk("reset_busy0", fetch(2), 32'h0);
        chk("reset_busyvec", fetch(4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read on both ports
        idle();
        bus_a.wr_en         = 2'b01;
        bus_a.wr_addr[4:0]  = 5'd5;
        bus_a.wr_data[31:0] = 32'h1234_5678;
        push("rd0_reg0_initial", 0, 32'h0);
        push("busyvec_plain_write", 4, 32'h0);
        tick();
        idle();
        bus_a.rd_addr = {5'd5, 5'd5};
        push("rd0_reg5", 0, 32'h1234_5678);
        push("rd1_reg5", 1, 32'h1234_5678);
        push("rdbusy0_reg5", 2, 32'h0);
        tick();

        // Two write ports to one address: port 1 wins
        idle();
        bus_a.wr_en        = 2'b11;
        bus_a.wr_addr      = {5'd7, 5'd7};
        bus_a.wr_data      = {32'h0000_5555, 32'h0000_AAAA};
        bus_a.rd_addr[4:0] = 5'd7;
        push("rd0_reg7_same_cycle", 0, BYP ? 32'h0000_5555 : 32'h0);
        tick();
        idle();
        bus_a.rd_addr = {5'd7, 5'd7};
        push("rd0_reg7_conflict", 0, 32'h0000_5555);
        push("rd1_reg7_conflict", 1, 32'h0000_5555);
        tick();

        // Register 0: hardwired in A, ordinary in B
        idle();
        bus_a.wr_en         = 2'b01;
        bus_a.wr_data[31:0] = 32'hFFFF_FFFF;
        bus_a.iss_en        = 1'b1;
        bus_b.wr_en         = 1'b1;
        bus_b.wr_data       = 32'hFFFF_FFFF;
        bus_b.iss_en        = 1'b1;
        push("a_busyvec_zero_issue", 4, 32'h0);
        push("b_busyvec_zero_issue", 7, 32'h1);
        tick();
        idle();
        push("a_rd0_reg0", 0, 32'h0);
        push("a_rd1_reg0", 1, 32'h0);
        push("a_rdbusy0_reg0", 2, 32'h0);
        push("b_rd_reg0", 5, 32'hFFFF_FFFF);
        push("b_rdbusy_reg0", 6, 32'h1);
        tick();

        // Scoreboard set / set-wins / clear on reg 3
        idle();
        bus_a.iss_en       = 1'b1;
        bus_a.iss_addr     = 5'd3;
        bus_a.rd_addr[4:0] = 5'd3;
        push("rdbusy0_issue_edge", 2, BYP ? 32'h1 : 32'h0);
        push("busyvec_after_issue", 4, 32'h8);
        tick();
        idle();
        bus_a.rd_addr[4:0] = 5'd3;
        push("rdbusy0_busy_reg3", 2, 32'h1);
        push("busyvec_hold", 4, 32'h8);
        tick();
        idle();
        bus_a.wr_en         = 2'b01;
        bus_a.wr_addr[4:0]  = 5'd3;
        bus_a.wr_data[31:0] = 32'h0000_0033;
        bus_a.iss_en        = 1'b1;
        bus_a.iss_addr      = 5'd3;
        bus_a.rd_addr[4:0]  = 5'd3;
        push("rdbusy0_set_wins", 2, 32'h1);
        push("rd0_reg3_write_issue", 0, BYP ? 32'h0000_0033 : 32'h0);
        push("busyvec_set_wins", 4, 32'h8);
        tick();
        idle();
        bus_a.wr_en          = 2'b10;
        bus_a.wr_addr[9:5]   = 5'd3;
        bus_a.wr_data[63:32] = 32'h0000_0044;
        bus_a.rd_addr[4:0]   = 5'd3;
        push("rdbusy0_clear_edge", 2, BYP ? 32'h0 : 32'h1);
        push("rd0_reg3_clear_edge", 0, BYP ? 32'h0000_0044 : 32'h0000_0033);
        push("busyvec_after_clear", 4, 32'h0);
        tick();
        idle();
        bus_a.rd_addr[4:0] = 5'd3;
        push("rd0_reg3_final", 0, 32'h0000_0044);
        push("rdbusy0_reg3_final", 2, 32'h0);
        tick();

        // Same-cycle read/write of reg 9
        idle();
        bus_a.wr_en         = 2'b01;
        bus_a.wr_addr[4:0]  = 5'd9;
        bus_a.wr_data[31:0] = 32'h0000_0001;
        tick();
        idle();
        bus_a.wr_en         = 2'b01;
        bus_a.wr_addr[4:0]  = 5'd9;
        bus_a.wr_data[31:0] = 32'h0000_CAFE;
        bus_a.rd_addr[9:5]  = 5'd9;
        push("rd1_reg9_bypass", 1, BYP ? 32'h0000_CAFE : 32'h0000_0001);
        tick();
        idle();
        bus_a.rd_addr = {5'd9, 5'd9};
        push("rd0_reg9_after", 0, 32'h0000_CAFE);
        push("rd1_reg9_after", 1, 32'h0000_CAFE);
        tick();

        // Top register, then asynchronous reset mid-run
        idle();
        bus_a.wr_en          = 2'b10;
        bus_a.wr_addr[9:5]   = 5'd31;
        bus_a.wr_data[63:32] = 32'hDEAD_BEEF;
        bus_a.iss_en         = 1'b1;
        bus_a.iss_addr       = 5'd31;
        tick();
        idle();
        bus_a.rd_addr = {5'd31, 5'd31};
        push("rd0_reg31", 0, 32'hDEAD_BEEF);
        push("rd1_reg31", 1, 32'hDEAD_BEEF);
        push("rdbusy0_reg31", 2, 32'h1);
        push("rdbusy1_reg31", 3, 32'h1);
        push("busyvec_reg31", 4, 32'h8000_0000);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd0", fetch(0), 32'h0);
        chk("async_rst_rd1", fetch(1), 32'h0);
        chk("async_rst_busy0", fetch(2), 32'h0);
        chk("async_rst_busy1", fetch(3), 32'h0);
        chk("async_rst_busyvec", fetch(4), 32'h0);
        chk("async_rst_b_rd", fetch(5), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push("rd0_reg31_post_reset", 0, 32'h0);
        push("rd1_reg31_post_reset", 1, 32'h0);
        push("rdbusy0_post_reset", 2, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the datapath.
- Configurable width, depth, read-port count and write-port count.
- Registered (1-cycle) reads, optional hardwired-zero register 0, and a per-register busy scoreboard for in-flight writes.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of 2, >=2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NREAD, 2, read ports (1..4)
- NWRITE, 1, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NREAD*WIDTH  packed registered read data
- rd_busy  out  NREAD  registered busy flag of the addressed register
- wr_en  in  NWRITE  per-port write enable
- wr_addr  in  NWRITE*AW  packed write addresses
- wr_data  in  NWRITE*WIDTH  packed write data
- iss_en  in  1  mark iss_addr busy (producer issued)
- iss_addr  in  AW  register being allocated
- busy_vec  out  DEPTH  current scoreboard, unregistered view of state

Behaviour:
- Reset (reset=0, async):
  - all DEPTH registers = 0, including index DEPTH-1;
  - rd_data = 0, rd_busy = 0, busy_vec = 0.
  - Holds while low; first normal cycle is the first rising edge after reset rises.
- Read latency 1: rd_data[p] and rd_busy[p] at edge n+1 reflect rd_addr[p] sampled at edge n. All read ports are independent; any may alias another.
- Write: at the rising edge with wr_en[w]=1, reg[wr_addr[w]] <= wr_data[w]. Takes effect for reads sampled at the following edge (subject to the optional bypass).
- Two write ports, same address, same cycle: higher port index wins.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - reads of 0 return 0;
  - iss_en to 0 is ignored;
  - busy[0] is always 0.
- Scoreboard, one busy bit per register:
  - set at the edge where iss_en=1 for iss_addr;
  - cleared at the edge where any wr_en[w]=1 targets that address.
  - Same address set and cleared in the same cycle: set wins (a new producer replaces the old).
  - iss_en to an already-busy register: stays busy; not an error.
  - Write to a non-busy register: data written, busy stays 0.
- rd_busy uses the scoreboard state before the current edge's update, unless REGFILE_BYPASS_EN is defined (see below).
- Out-of-range addresses are impossible (AW exact).
- No X on outputs after reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - a read sampled in the same cycle as a write to the same address returns the new wr_data (highest write-port match wins);
  - rd_busy reflects the post-update scoreboard (write clear and issue set applied, set wins).
  - Register 0 is still forced to 0 when ZERO_REG=1.
- Undefined: same-cycle read returns the old register value and rd_busy shows the pre-update busy bit.
- Array contents are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_NREAD=2, RF_NWRITE=1;
  - typedef rf_word_t (logic [RF_WIDTH-1:0]) and rf_addr_t.
- Sub-module regfile_scoreboard (DEPTH, AW, NWRITE, ZERO_REG):
  - owns the busy bits and the set/clear priority;
  - outputs the current and next busy vectors.
- Top owns the storage array, write-port priority, read registers and bypass mux.

Test Plan:
- Reset: drive reset low mid-run after writing 0xDEADBEEF to reg 31 -> rd_data and rd_busy immediately 0; reading reg 31 after release returns 0.
- Basic R/W: write 0x12345678 to reg 5 at edge n; rd_addr=5 sampled at n+1 -> rd_data=0x12345678 at n+2. Port 1 reading reg 5 simultaneously shows the same value.
- Zero reg (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and iss_en on 0 -> reads return 0, busy_vec[0]=0. With ZERO_REG=0 the same sequence reads 0xFFFFFFFF.
- Write conflict (NWRITE=2): port0 writes 0xAAAA, port1 writes 0x5555, both to reg 7 in the same cycle -> reg 7 = 0x5555.
- Scoreboard: iss_en reg 3 at edge n -> busy_vec[3]=1. Write reg 3 together with iss_en reg 3 at edge n+2 -> busy_vec[3] stays 1. Write reg 3 alone at n+3 -> busy_vec[3]=0.
- Bypass: read and write reg 9 (0xCAFE) in the same cycle, old value 0x1 -> rd_data=0xCAFE with REGFILE_BYPASS_EN defined, 0x1 without. rd_busy follows the same pre/post rule.
